axi4_lite_cmd_master: RTL and testbench

- Single-outstanding AXI4-Lite master that converts a simple valid/ready command stream into AXI4-Lite read and write transactions.
- Sits directly upstream of the LSTM AXI4-Lite register/cache slave. Used by the on-chip sequencer and the testbench host model to load weights and read back results.
- Returns one response per command on a valid/ready response stream. A per-transaction timeout keeps a hung slave from stalling the sequencer forever.

---
 rtl/axi4_lite_cmd_master_if.sv | 36 +++
 rtl/axi4_lite_cmd_master.sv | 98 +++++++++
 tb/tb_axi4_lite_cmd_master.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_cmd_master_if.sv
// axi4_lite_cmd_master_if: AXI4-Lite bus between the command master and its slave
interface axi4_lite_cmd_master_if;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );
  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi4_lite_cmd_master.sv
// axi4_lite_cmd_master: single-outstanding AXI4-Lite master driven by a cmd/rsp stream
module axi4_lite_cmd_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]           cmd_data,
  input  logic [3:0]            cmd_strb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [31:0]           rsp_data,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,
  axi4_lite_cmd_master_if.master axi
);
  localparam int CNT_WIDTH = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  typedef enum logic [2:0] {IDLE, WRITE, WRESP, RADDR, RDATA, RESP} state_t;
  state_t state, state_n;
  logic [31:0] addr_q, data_q;
  logic [3:0]  strb_q;
  logic [CNT_WIDTH-1:0] cnt;
  logic aw_pend, w_pend, ar_pend;
  logic accept, busy, wr_done, b_done, ar_done, r_done, abort;
  assign accept  = cmd_valid && cmd_ready;
  assign busy    = state inside {WRITE, WRESP, RADDR, RDATA};
  assign wr_done = state == WRITE && (!aw_pend || axi.awready) && (!w_pend || axi.wready);
  assign b_done  = state == WRESP && axi.bvalid;
  assign ar_done = state == RADDR && axi.arready;
  assign r_done  = state == RDATA && axi.rvalid;
  // expiry fires on the last allowed cycle so the valid is up for exactly TIMEOUT_CYCLES
  assign abort   = TIMEOUT_CYCLES > 0 && busy && cnt == CNT_LAST && !(wr_done || b_done || ar_done || r_done);
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = accept ? (cmd_write ? WRITE : RADDR) : IDLE;
      WRITE:   state_n = wr_done ? WRESP : WRITE;
      WRESP:   state_n = b_done ? RESP : WRESP;
      RADDR:   state_n = ar_done ? RDATA : RADDR;
      RDATA:   state_n = r_done ? RESP : RDATA;
      RESP:    state_n = rsp_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
    if (abort) state_n = RESP;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      addr_q      <= '0;
      data_q      <= '0;
      strb_q      <= '0;
      cnt         <= '0;
      aw_pend     <= 1'b0;
      w_pend      <= 1'b0;
      ar_pend     <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_data    <= '0;
      rsp_resp    <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      if (accept) begin
        addr_q    <= 32'(cmd_addr);
        data_q    <= cmd_data;
        strb_q    <= cmd_strb;
        rsp_write <= cmd_write;
        cnt       <= '0;
      end else if (busy) cnt <= cnt + 1'b1;
      aw_pend <= accept ? cmd_write : aw_pend && !axi.awready && !abort;
      w_pend  <= accept ? cmd_write : w_pend && !axi.wready && !abort;
      ar_pend <= accept ? !cmd_write : ar_pend && !axi.arready && !abort;
      if (b_done || r_done || abort) begin
        rsp_data    <= r_done ? axi.rdata : '0;
        rsp_resp    <= abort ? 2'b10 : b_done ? axi.bresp : axi.rresp;
        rsp_timeout <= abort;
      end
    end
  assign cmd_ready  = state == IDLE && rst;
  assign rsp_valid  = state == RESP;
  assign axi.awaddr  = addr_q;
  assign axi.awprot  = 3'b000;
  assign axi.awvalid = aw_pend;
  assign axi.wdata   = data_q;
  assign axi.wstrb   = strb_q;
  assign axi.wvalid  = w_pend;
  assign axi.bready  = state == WRESP;
  assign axi.araddr  = addr_q;
  assign axi.arprot  = 3'b000;
  assign axi.arvalid = ar_pend;
  assign axi.rready  = state == RDATA;
endmodule

// File: tb/tb_axi4_lite_cmd_master.sv
// tb_axi4_lite_cmd_master: directed checks of write, read, backpressure, timeout and reset
module tb_axi4_lite_cmd_master;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_data;
  logic [3:0]  cmd_strb;
  logic rsp_valid, rsp_ready, rsp_write, rsp_timeout;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_resp;
  int checks = 0;
  int errors = 0;
  axi4_lite_cmd_master_if bus();
  axi4_lite_cmd_master #(.ADDR_WIDTH(16), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_data(rsp_data), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .axi(bus.master)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic send(input logic wr, input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_strb  = s;
  endtask
  initial begin
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_data = '0; cmd_strb = '0; rsp_ready = 0;
    bus.awready = 1; bus.wready = 1; bus.bvalid = 0; bus.bresp = '0;
    bus.arready = 1; bus.rdata = '0; bus.rresp = '0; bus.rvalid = 0;
    tick; tick;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_awvalid", bus.awvalid, 0);
    check("rst_arvalid", bus.arvalid, 0);
    check("rst_bready", bus.bready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_awaddr", bus.awaddr, 0);
    check("rst_rsp_data", rsp_data, 0);
    rst = 1;
    #1 check("release_cmd_ready", cmd_ready, 1);
    send(1, 16'h0010, 32'hDEADBEEF, 4'hF);
    tick;
    cmd_valid = 0;
    check("w1_awvalid", bus.awvalid, 1);
    check("w1_wvalid", bus.wvalid, 1);
    check("w1_awaddr", bus.awaddr, 32'h10);
    check("w1_wdata", bus.wdata, 32'hDEADBEEF);
    check("w1_wstrb", bus.wstrb, 4'hF);
    check("w1_awprot", bus.awprot, 0);
    tick;
    check("w1_awvalid_drop", bus.awvalid, 0);
    check("w1_wvalid_drop", bus.wvalid, 0);
    check("w1_bready", bus.bready, 1);
    check("w1_no_rsp_yet", rsp_valid, 0);
    bus.bvalid = 1; bus.bresp = 2'b00;
    tick;
    bus.bvalid = 0;
    check("w1_rsp_valid", rsp_valid, 1);
    check("w1_rsp_write", rsp_write, 1);
    check("w1_rsp_resp", rsp_resp, 0);
    check("w1_rsp_timeout", rsp_timeout, 0);
    check("w1_rsp_data", rsp_data, 0);
    rsp_ready = 1;
    tick;
    rsp_ready = 0;
    check("w1_rsp_done", rsp_valid, 0);
    check("w1_cmd_ready", cmd_ready, 1);
    bus.wready = 0;
    send(1, 16'h0020, 32'h12345678, 4'h3);
    tick;
    cmd_valid = 0;
    check("w2_awvalid", bus.awvalid, 1);
    check("w2_wvalid", bus.wvalid, 1);
    for (int i = 2; i <= 4; i++) begin
      tick;
      check("w2_awvalid_low", bus.awvalid, 0);
      check("w2_wvalid_hold", bus.wvalid, 1);
      check("w2_wdata_hold", bus.wdata, 32'h12345678);
      check("w2_wstrb_hold", bus.wstrb, 4'h3);
    end
    bus.wready = 1;
    tick;
    check("w2_wvalid_drop", bus.wvalid, 0);
    check("w2_bready", bus.bready, 1);
    bus.bvalid = 1; bus.bresp = 2'b11;
    tick;
    bus.bvalid = 0;
    check("w2_rsp_valid", rsp_valid, 1);
    check("w2_rsp_resp", rsp_resp, 2'b11);
    check("w2_rsp_timeout", rsp_timeout, 0);
    rsp_ready = 1;
    tick;
    rsp_ready = 0;
    check("w2_single_rsp_a", rsp_valid, 0);
    tick;
    check("w2_single_rsp_b", rsp_valid, 0);
    send(0, 16'h0010, 32'h0, 4'h0);
    tick;
    cmd_valid = 0;
    check("r1_arvalid", bus.arvalid, 1);
    check("r1_araddr", bus.araddr, 32'h10);
    check("r1_arprot", bus.arprot, 0);
    tick;
    check("r1_arvalid_drop", bus.arvalid, 0);
    check("r1_rready", bus.rready, 1);
    tick;
    check("r1_no_rsp_yet", rsp_valid, 0);
    bus.rvalid = 1; bus.rdata = 32'hDEADBEEF; bus.rresp = 2'b00;
    tick;
    bus.rvalid = 0; bus.rdata = '0;
    check("r1_rsp_valid", rsp_valid, 1);
    check("r1_rsp_data", rsp_data, 32'hDEADBEEF);
    check("r1_rsp_write", rsp_write, 0);
    check("r1_rsp_resp", rsp_resp, 0);
    bus.arready = 0;
    send(0, 16'hFF10, 32'h0, 4'h0);
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_data", rsp_data, 32'hDEADBEEF);
      check("bp_rsp_write", rsp_write, 0);
      check("bp_cmd_ready", cmd_ready, 0);
      tick;
    end
    check("bp_last_cmd_ready", cmd_ready, 0);
    rsp_ready = 1;
    tick;
    rsp_ready = 0;
    check("bp_rsp_done", rsp_valid, 0);
    check("bp_next_cmd_ready", cmd_ready, 1);
    tick;
    cmd_valid = 0;
    check("to_arvalid", bus.arvalid, 1);
    check("to_araddr_zext", bus.araddr, 32'h0000FF10);
    for (int i = 0; i < 7; i++) begin
      tick;
      check("to_arvalid_hold", bus.arvalid, 1);
      check("to_no_rsp", rsp_valid, 0);
    end
    tick;
    check("to_arvalid_drop", bus.arvalid, 0);
    check("to_rready", bus.rready, 0);
    check("to_rsp_valid", rsp_valid, 1);
    check("to_rsp_resp", rsp_resp, 2'b10);
    check("to_rsp_timeout", rsp_timeout, 1);
    check("to_rsp_data", rsp_data, 0);
    rsp_ready = 1;
    tick;
    rsp_ready = 0;
    bus.arready = 1;
    check("to_cmd_ready", cmd_ready, 1);
    send(1, 16'h0030, 32'h0000AA55, 4'hF);
    tick;
    cmd_valid = 0;
    tick;
    check("rs_bready", bus.bready, 1);
    #2 rst = 0;
    #1;
    check("rs_bready_async", bus.bready, 0);
    check("rs_rsp_valid", rsp_valid, 0);
    check("rs_rsp_timeout", rsp_timeout, 0);
    check("rs_cmd_ready", cmd_ready, 0);
    check("rs_wdata", bus.wdata, 0);
    tick;
    rst = 1;
    bus.bvalid = 1;
    #1 check("rs_release_cmd_ready", cmd_ready, 1);
    tick;
    bus.bvalid = 0;
    check("rs_no_stray_a", rsp_valid, 0);
    check("rs_cmd_ready_hold", cmd_ready, 1);
    tick;
    check("rs_no_stray_b", rsp_valid, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
